alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue stage sitting directly upstream of the execute-stage ALU.
- Takes a fetched MIPS-32 integer instruction plus register-file read values.
- Produces the registered 12-bit one-hot alu_control word, alu_src1, alu_src2 and the destination register number.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from execute never drops or duplicates an instruction.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- inst  in  32  instruction word
- rs_value  in  32  register-file value of inst[25:21]
- rt_value  in  32  register-file value of inst[20:16]
- out_valid  out  1  issued operation valid
- out_ready  in  1  execute stage accepts this cycle
- alu_control  out  12  one-hot: [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui
- alu_src1  out  32  ALU operand 1 (shift amount in [4:0] for shifts)
- alu_src2  out  32  ALU operand 2
- dest  out  5  write-back register number
- illegal  out  1  unsupported opcode/funct

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high.
- Reset: out_valid=0, skid empty, alu_control=0, alu_src1=0, alu_src2=0, dest=0, illegal=0; in_ready=0 while reset is high, 1 the cycle after.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: instruction accepted in cycle N appears on the outputs in N+1 when the output register is empty or drained in N.
- in_ready = !skid_valid (registered, no combinational path from out_ready).
- State machine:
  - EMPTY: accept goes to the output register → ONE.
  - ONE:
    - Accept without drain: goes to skid → FULL.
    - Accept with drain: replaces the output register, stays ONE.
    - Drain without accept → EMPTY.
  - FULL: drain moves skid to the output register → ONE; no accept is possible.
- Ordering: strict FIFO, no reordering.
- Output stability: outputs stay stable while out_valid && !out_ready.
- Decode: one-hot alu_control, exactly one bit set, or zero when illegal.
- R-type (op=0), dest=rd:
  - funct 20/21 → add; 22/23 → sub; 24 and; 25 or; 26 xor; 27 nor; 2A slt; 2B sltu.
  - For these, src1=rs_value, src2=rt_value.
- Shifts, dest=rd, src2=rt_value:
  - funct 00 sll, 02 srl, 03 sra: src1={27'b0,inst[10:6]}.
  - funct 04 sllv, 06 srlv, 07 srav: src1=rs_value.
- I-type, dest=rt, src1=rs_value:
  - op 08/09 → add, sign-extended imm.
  - 0A slti, 0B sltiu: sign-extended imm.
  - 0C andi, 0D ori, 0E xori: zero-extended imm.
  - 0F lui: src2={16'b0,imm}, src1=0.
- Overflow: add/addi are not trapped; they behave as addu/addiu.
- Illegal: any other opcode/funct → illegal=1, alu_control=0, src1=src2=0, dest=0. It is still issued through the handshake.
- Stalls: inst/rs_value/rt_value are sampled only on an accept cycle; changes during stall are ignored.
- Reset mid-operation: both entries discarded; no output transfer in the reset cycle.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Extra ports when defined:
  - wb_we  in  1
  - wb_dest  in  5
  - wb_value  in  32
- With the macro: on accept, if wb_we && wb_dest!=0 && wb_dest==rs field, wb_value replaces rs_value. The same rule applies independently for rt.
- Without the macro: the ports are absent and rs_value/rt_value are used unmodified.

Test Plan:
- addiu $2,$1,-1: inst=0x2422FFFF, rs_value=5, out_ready=1 → next cycle out_valid=1, alu_control=0x800, src1=5, src2=0xFFFFFFFF, dest=2.
- sll $3,$4,4: inst=0x00041900, rt_value=0xF → alu_control=0x008, src1=4, src2=0xF, dest=3. lui $5,0x1234 (0x3C051234) → alu_control=0x001, src2=0x00001234, dest=5.
- ori $6,$5,0x8000: inst=0x34A68000 → alu_control=0x020, src2=0x00008000 (zero-extended), dest=6.
- Back-pressure:
  - Sequence: out_ready=0, send A, B, C back-to-back.
  - in_ready drops after B is accepted; C is held upstream.
  - Raise out_ready: A, B, C emerge in order, each exactly once, with no bubble between A and B.
- inst=0xFC000000 → illegal=1, alu_control=0, dest=0. Assert reset while FULL → next cycle out_valid=0; in_ready=1 one cycle after reset deasserts.
- With ALU_ISSUE_FWD_EN: addu $7,$1,$2 (0x00223821), wb_we=1, wb_dest=1, wb_value=0xAA → src1=0xAA. Repeat with wb_dest=0 → src1=rs_value.

Source files
------------

// File: rtl/alu_issue_stage.sv
// MIPS-32 integer decode/issue stage feeding the execute ALU through a 2-entry skid buffer.
// Define ALU_ISSUE_FWD_EN to add the write-back forwarding ports (wb_we/wb_dest/wb_value).
module alu_issue_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
`ifdef ALU_ISSUE_FWD_EN
    input  logic              wb_we,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [4:0]        dest,
    output logic              illegal
);

    localparam logic [11:0] CTL_ADD  = 12'h800;
    localparam logic [11:0] CTL_SUB  = 12'h400;
    localparam logic [11:0] CTL_SLT  = 12'h200;
    localparam logic [11:0] CTL_SLTU = 12'h100;
    localparam logic [11:0] CTL_AND  = 12'h080;
    localparam logic [11:0] CTL_NOR  = 12'h040;
    localparam logic [11:0] CTL_OR   = 12'h020;
    localparam logic [11:0] CTL_XOR  = 12'h010;
    localparam logic [11:0] CTL_SLL  = 12'h008;
    localparam logic [11:0] CTL_SRL  = 12'h004;
    localparam logic [11:0] CTL_SRA  = 12'h002;
    localparam logic [11:0] CTL_LUI  = 12'h001;

    typedef struct packed {
        logic [11:0]       ctl;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [4:0]        dest;
        logic              illegal;
    } issue_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rt_f;
    logic [4:0]        rd_f;
    logic [4:0]        sa_f;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_op;
    logic [DATA_W-1:0] rt_op;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] zimm;

    assign op    = inst[31:26];
    assign rt_f  = inst[20:16];
    assign rd_f  = inst[15:11];
    assign sa_f  = inst[10:6];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];
    assign simm  = {{(DATA_W-16){imm[15]}}, imm};
    assign zimm  = {{(DATA_W-16){1'b0}}, imm};

`ifdef ALU_ISSUE_FWD_EN
    // A register being written back this cycle is newer than the register-file read.
    assign rs_op = (wb_we && wb_dest != 5'd0 && wb_dest == inst[25:21]) ? wb_value : rs_value;
    assign rt_op = (wb_we && wb_dest != 5'd0 && wb_dest == rt_f)        ? wb_value : rt_value;
`else
    logic unused_rs_field;
    assign unused_rs_field = ^inst[25:21];
    assign rs_op = rs_value;
    assign rt_op = rt_value;
`endif

    issue_t dec;
    logic   legal;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        dec   = '0;
        legal = 1'b1;
        if (op == 6'h00) begin
            dec.dest = rd_f;
            dec.src1 = rs_op;
            dec.src2 = rt_op;
            case (funct)
                6'h20, 6'h21: dec.ctl = CTL_ADD;
                6'h22, 6'h23: dec.ctl = CTL_SUB;
                6'h24:        dec.ctl = CTL_AND;
                6'h25:        dec.ctl = CTL_OR;
                6'h26:        dec.ctl = CTL_XOR;
                6'h27:        dec.ctl = CTL_NOR;
                6'h2A:        dec.ctl = CTL_SLT;
                6'h2B:        dec.ctl = CTL_SLTU;
                6'h00: begin dec.ctl = CTL_SLL; dec.src1 = DATA_W'(sa_f); end
                6'h02: begin dec.ctl = CTL_SRL; dec.src1 = DATA_W'(sa_f); end
                6'h03: begin dec.ctl = CTL_SRA; dec.src1 = DATA_W'(sa_f); end
                6'h04:        dec.ctl = CTL_SLL;
                6'h06:        dec.ctl = CTL_SRL;
                6'h07:        dec.ctl = CTL_SRA;
                default:      legal = 1'b0;
            endcase
        end else begin
            dec.dest = rt_f;
            dec.src1 = rs_op;
            case (op)
                6'h08, 6'h09: begin dec.ctl = CTL_ADD;  dec.src2 = simm; end
                6'h0A:        begin dec.ctl = CTL_SLT;  dec.src2 = simm; end
                6'h0B:        begin dec.ctl = CTL_SLTU; dec.src2 = simm; end
                6'h0C:        begin dec.ctl = CTL_AND;  dec.src2 = zimm; end
                6'h0D:        begin dec.ctl = CTL_OR;   dec.src2 = zimm; end
                6'h0E:        begin dec.ctl = CTL_XOR;  dec.src2 = zimm; end
                6'h0F: begin dec.ctl = CTL_LUI; dec.src1 = '0; dec.src2 = zimm; end
                default:      legal = 1'b0;
            endcase
        end
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    state_t state_q, state_d;
    issue_t out_q, out_d;
    issue_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (accept) begin out_d = dec; state_d = ONE; end
            ONE: begin
                if (accept && drain) begin
                    out_d = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL:    if (drain) begin out_d = skid_q; state_d = ONE; end
            default: state_d = EMPTY;
        endcase
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            // NOTE: payload registers are reset as well: the outputs must read zero after reset
            // and a cleared skid can never resurface a stale instruction.
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    // Masking with reset keeps execute from taking the entry being discarded this cycle.
    assign out_valid   = out_valid_q && !reset;
    assign in_ready    = in_ready_q;
    assign alu_control = out_q.ctl;
    assign alu_src1    = out_q.src1;
    assign alu_src2    = out_q.src2;
    assign dest        = out_q.dest;
    assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors plus randomized traffic
// compared against a queue-based reference model of the issue stage.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = '0;
    logic [31:0] rs_value = '0;
    logic [31:0] rt_value = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] alu_control;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [4:0]  dest;
    logic        illegal;

    alu_issue_stage #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inst       (inst),
        .rs_value   (rs_value),
        .rt_value   (rt_value),
`ifdef ALU_ISSUE_FWD_EN
        .wb_we      (wb_we),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_control(alu_control),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .dest       (dest),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] ctl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   exp_ready;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [5:0] r_functs [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h05};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference decode: ALU bit position 11..0 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] rsv, input logic [31:0] rtv);
        exp_t        e;
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] simm;
        logic [31:0] zimm;
        e    = '0;
        idx  = -1;
        a    = rsv;
        b    = rtv;
        simm = {{16{w[15]}}, w[15:0]};
        zimm = {16'h0, w[15:0]};
        if (FWD && wb_we && wb_dest != 0 && wb_dest == w[25:21]) a = wb_value;
        if (FWD && wb_we && wb_dest != 0 && wb_dest == w[20:16]) b = wb_value;
        if (w[31:26] == 6'h00) begin
            e.dest = w[15:11];
            e.src1 = a;
            e.src2 = b;
            case (w[5:0])
                6'h20, 6'h21: idx = 11;
                6'h22, 6'h23: idx = 10;
                6'h2A: idx = 9;
                6'h2B: idx = 8;
                6'h24: idx = 7;
                6'h27: idx = 6;
                6'h25: idx = 5;
                6'h26: idx = 4;
                6'h00: begin idx = 3; e.src1 = 32'(w[10:6]); end
                6'h02: begin idx = 2; e.src1 = 32'(w[10:6]); end
                6'h03: begin idx = 1; e.src1 = 32'(w[10:6]); end
                6'h04: idx = 3;
                6'h06: idx = 2;
                6'h07: idx = 1;
                default: idx = -1;
            endcase
        end else begin
            e.dest = w[20:16];
            e.src1 = a;
            case (w[31:26])
                6'h08, 6'h09: begin idx = 11; e.src2 = simm; end
                6'h0A: begin idx = 9; e.src2 = simm; end
                6'h0B: begin idx = 8; e.src2 = simm; end
                6'h0C: begin idx = 7; e.src2 = zimm; end
                6'h0D: begin idx = 5; e.src2 = zimm; end
                6'h0E: begin idx = 4; e.src2 = zimm; end
                6'h0F: begin idx = 0; e.src1 = 0; e.src2 = zimm; end
                default: idx = -1;
            endcase
        end
        if (idx < 0) begin
            e     = '0;
            e.ill = 1'b1;
        end else begin
            e.ctl = 12'(1) << idx;
        end
        return e;
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (q.size() > 0) begin
            check("alu_control", 32'(alu_control), 32'(q[0].ctl));
            check("alu_src1", alu_src1, q[0].src1);
            check("alu_src2", alu_src2, q[0].src2);
            check("dest", 32'(dest), 32'(q[0].dest));
            check("illegal", 32'(illegal), 32'(q[0].ill));
        end
    endtask

    // Called at a falling edge: drive one cycle, advance the model, sample at the next falling edge.
    task automatic step(input bit iv, input logic [31:0] w, input logic [31:0] rsv,
                        input logic [31:0] rtv, input bit ordy);
        bit acc;
        bit drn;
        in_valid  = iv;
        inst      = w;
        rs_value  = rsv;
        rt_value  = rtv;
        out_ready = ordy;
        acc = iv && exp_ready;
        drn = (q.size() > 0) && ordy;
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(model(w, rsv, rtv));
        @(posedge clk);
        exp_ready = (q.size() < 2);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_no_xfer", 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_alu_control", 32'(alu_control), 0);
        check("rst_src1", alu_src1, 0);
        check("rst_src2", alu_src2, 0);
        check("rst_dest", 32'(dest), 0);
        check("rst_illegal", 32'(illegal), 0);
        reset = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        exp_ready = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          sel;
        w   = $urandom();
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
            w[31:26] = 6'h00;
            w[5:0]   = r_functs[$urandom_range(0, 16)];
        end else if (sel < 8) begin
            w[31:26] = 6'(6'h08 + $urandom_range(0, 7));
        end else if (sel == 8) begin
            w[31:26] = 6'h00;
        end
        return w;
    endfunction

    localparam logic [31:0] INST_A = 32'h00223821;  // addu $7,$1,$2
    localparam logic [31:0] INST_B = 32'h00644022;  // sub  $8,$3,$4
    localparam logic [31:0] INST_C = 32'h00A64826;  // xor  $9,$5,$6

    initial begin
        exp_ready = 1'b0;
        @(negedge clk);
        do_reset();

        step(1'b1, 32'h2422FFFF, 32'd5, 32'd0, 1'b1);
        check("addiu_ctl", 32'(alu_control), 32'h800);
        check("addiu_src1", alu_src1, 32'd5);
        check("addiu_src2", alu_src2, 32'hFFFFFFFF);
        check("addiu_dest", 32'(dest), 32'd2);

        step(1'b1, 32'h00041900, 32'h123, 32'hF, 1'b1);
        check("sll_ctl", 32'(alu_control), 32'h008);
        check("sll_src1", alu_src1, 32'd4);
        check("sll_src2", alu_src2, 32'hF);
        check("sll_dest", 32'(dest), 32'd3);

        step(1'b1, 32'h3C051234, 32'h77, 32'h0, 1'b1);
        check("lui_ctl", 32'(alu_control), 32'h001);
        check("lui_src1", alu_src1, 32'd0);
        check("lui_src2", alu_src2, 32'h00001234);
        check("lui_dest", 32'(dest), 32'd5);

        step(1'b1, 32'h34A68000, 32'h1, 32'h0, 1'b1);
        check("ori_ctl", 32'(alu_control), 32'h020);
        check("ori_src2", alu_src2, 32'h00008000);
        check("ori_dest", 32'(dest), 32'd6);

        step(1'b1, 32'hFC000000, 32'h55, 32'h66, 1'b1);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_ctl", 32'(alu_control), 32'd0);
        check("ill_dest", 32'(dest), 32'd0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Back-pressure: A, B, C offered back-to-back while execute stalls.
        step(1'b1, INST_A, 32'h11, 32'h22, 1'b0);
        check("bp_a_ready", 32'(in_ready), 32'd1);
        step(1'b1, INST_B, 32'h33, 32'h44, 1'b0);
        check("bp_ready_drop", 32'(in_ready), 32'd0);
        check("bp_hold_a", 32'(dest), 32'd7);
        step(1'b1, INST_C, 32'h55, 32'h66, 1'b0);
        step(1'b1, INST_C, 32'h55, 32'h66, 1'b0);
        check("bp_still_a", 32'(dest), 32'd7);
        step(1'b1, INST_C, 32'h55, 32'h66, 1'b1);
        check("bp_no_bubble", 32'(out_valid), 32'd1);
        check("bp_b_dest", 32'(dest), 32'd8);
        step(1'b1, INST_C, 32'h55, 32'h66, 1'b1);
        check("bp_c_dest", 32'(dest), 32'd9);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset while both entries are occupied.
        step(1'b1, INST_A, 32'h1, 32'h2, 1'b0);
        step(1'b1, INST_B, 32'h3, 32'h4, 1'b0);
        check("full_before_rst", 32'(in_ready), 32'd0);
        do_reset();

`ifdef ALU_ISSUE_FWD_EN
        wb_we = 1'b1; wb_dest = 5'd1; wb_value = 32'hAA;
        step(1'b1, INST_A, 32'h5, 32'h6, 1'b1);
        check("fwd_rs_hit", alu_src1, 32'hAA);
        wb_dest = 5'd0;
        step(1'b1, INST_A, 32'h5, 32'h6, 1'b1);
        check("fwd_r0_ignored", alu_src1, 32'h5);
        wb_we = 1'b0;
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
`endif

        for (int i = 0; i < 2000; i++) begin
            wb_we    = 1'($urandom_range(0, 1));
            wb_dest  = 5'($urandom_range(0, 3));
            wb_value = $urandom();
            step($urandom_range(0, 9) < 7, rand_inst(), $urandom(), $urandom(),
                 $urandom_range(0, 9) < 6);
            if (i == 1000) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
